alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one 64-bit two-operand ALU between two requesters: port 0 (execute stage) and port 1 (auxiliary address/loop unit).
- Round-robin arbitration, valid/ready handshake on each request port, and a registered result with requester tag.
- Owns the Y86-64 condition-code register (ZF, SF, OF), updated only by port-0 operations that request it.
- Instantiates the team's ALU_64 and drives its opcode and operands.

Parameters:
- W, 64, operand/result width; ALU_64 is 64-bit, so only 64 is supported.
- RR_INIT, 0, requester favoured first after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port-0 request valid
- req0_ready  output  1  port-0 request accepted this cycle
- req0_op  input  2  00 ADD, 01 SUB (a-b), 10 AND, 11 XOR
- req0_a  input  W  operand a
- req0_b  input  W  operand b
- req0_setcc  input  1  update CC when this op completes
- req1_valid  input  1  port-1 request valid
- req1_ready  output  1  port-1 request accepted
- req1_op  input  2  opcode, same encoding as req0_op
- req1_a  input  W  operand a
- req1_b  input  W  operand b
- lock1  input  1  see Optional Feature; ignored when feature absent
- rsp_valid  output  1  result register holds an unconsumed result
- rsp_ready  input  1  consumer accepts result
- rsp_tag  output  1  requester that owns the result
- rsp_data  output  W  ALU result
- cc_zf  output  1  zero flag
- cc_sf  output  1  sign flag
- cc_of  output  1  signed overflow flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: rsp_valid=0, rsp_tag=0, rsp_data=0, cc_zf=1, cc_sf=0, cc_of=0, priority pointer=RR_INIT. ready outputs are 0 while reset is asserted.
- Slot free: free = !rsp_valid || rsp_ready.
- Grant rules:
  - When free and exactly one req*_valid is high, that port is granted.
  - When both are valid, the port named by the pointer is granted and the pointer then moves to the other port.
  - A grant to a lone requester also sets the pointer to the other port.
- Ready: req*_ready is combinational and is 1 only for the granted port in a free cycle. Grant does not wait for valid to stay high.
- Latency: the operands of the granted port drive ALU_64 combinationally. Result, tag and rsp_valid=1 are registered on the same edge as acceptance, so latency is 1 cycle.
- Throughput: back-to-back issue is allowed when rsp_ready=1 (one op per cycle).
- Result hold: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_tag are held stable and both ready outputs are 0.
- Draining: rsp_ready=1 with no new grant clears rsp_valid.
- State machine: IDLE (rsp_valid=0) and FULL (rsp_valid=1).
  - IDLE to FULL on grant.
  - FULL to FULL on rsp_ready with a grant.
  - FULL to IDLE on rsp_ready with no grant.
  - FULL stays FULL while rsp_ready=0 (stall).
- Condition codes: updated on the acceptance edge only when the granted port is 0 and req0_setcc=1.
  - ZF = (res==0).
  - SF = res[63].
  - OF = ALU overflow for ADD/SUB, 0 for AND/XOR.
  - Port-1 ops never change CC.
- Arithmetic: two's complement, wrap-around modulo 2^64; overflow is signed overflow only.
- Reset mid-operation: a pending result is discarded and CC returns to reset values the next cycle.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined: when port 1 is granted with lock1=1, the arbiter keeps favouring port 1 while lock1 stays high. The pointer does not advance, and port 0 waits even when valid. The lock releases on the first grant with lock1=0, or on any cycle with req1_valid=0.
- Undefined: lock1 is unused and arbitration is pure round-robin.

Test Plan:
- Reset, then req0 ADD a=5 b=7 setcc=1, rsp_ready=1 -> next cycle rsp_valid=1, tag=0, data=12, ZF=0 SF=0 OF=0.
- req0 SUB a=0x8000000000000000 b=1 setcc=1 -> data=0x7FFFFFFFFFFFFFFF, OF=1, SF=0, ZF=0.
- Both ports valid for 4 cycles, RR_INIT=0, rsp_ready=1 -> grants 0,1,0,1. Port-1 XOR a=b=3 gives data=0, tag=1, and CC is unchanged.
- Result pending with rsp_ready=0 for 3 cycles -> both ready=0 and rsp_data stable. Raising rsp_ready gives a same-cycle acceptance of the next request.
- Reset asserted while rsp_valid=1 -> next cycle rsp_valid=0, cc_zf=1, pointer=RR_INIT.
- With ALU_ARB_LOCK_EN: req1 lock1=1 for 3 ops while req0 is valid -> three port-1 grants, then port 0 is granted after lock1 drops.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one 64-bit ALU_64, with a registered tagged result
// and the Y86-64 condition codes. Define ALU_ARB_LOCK_EN to let port 1 hold the ALU via lock1.

module ALU_64 (
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic        ovf
);
  always_comb begin
    res = 64'd0;
    ovf = 1'b0;
    case (op)
      2'b00: begin
        res = a + b;
        ovf = (a[63] == b[63]) && (res[63] != a[63]);
      end
      2'b01: begin
        res = a - b;
        ovf = (a[63] != b[63]) && (res[63] != a[63]);
      end
      2'b10: res = a & b;
      default: res = a ^ b;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int W       = 64,
  parameter int RR_INIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_setcc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         lock1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_tag,
  output logic [W-1:0] rsp_data,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  // Handshake: a request transfers on any edge where reqN_valid && reqN_ready; the result
  // transfers on any edge where rsp_valid && rsp_ready. Ready never depends on the next valid.
  typedef enum logic [0:0] {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t       state;
  logic         ptr;
  logic         free;
  logic         fav1;
  logic         g0;
  logic         g1;
  logic [1:0]   alu_op;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic [63:0]  alu_res;
  logic         alu_ovf;

`ifdef ALU_ARB_LOCK_EN
  logic lock_q;
  // Port 1 stays favoured only while the locking requester keeps lock1 high.
  assign fav1 = (lock_q && lock1) ? 1'b1 : ptr;
`else
  assign fav1 = ptr | (lock1 & 1'b0);
`endif

  assign free = (state == IDLE) || rsp_ready;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset && free) begin
      g1 = req1_valid && (!req0_valid || fav1);
      g0 = req0_valid && (!req1_valid || !fav1);
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rsp_valid  = (state == FULL);

  always_comb begin
    alu_op = g1 ? req1_op : req0_op;
    alu_a  = g1 ? req1_a  : req0_a;
    alu_b  = g1 ? req1_b  : req0_b;
  end

  ALU_64 u_alu (
    .op  (alu_op),
    .a   (alu_a),
    .b   (alu_b),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rsp_tag  <= 1'b0;
      rsp_data <= '0;
      cc_zf    <= 1'b1;
      cc_sf    <= 1'b0;
      cc_of    <= 1'b0;
      ptr      <= 1'(RR_INIT);
    end else begin
      if (g0 || g1) begin
        state    <= FULL;
        rsp_tag  <= g1;
        rsp_data <= alu_res;
        ptr      <= g0;
        if (g0 && req0_setcc) begin
          cc_zf <= (alu_res == 64'd0);
          cc_sf <= alu_res[63];
          cc_of <= (alu_op[1] == 1'b0) ? alu_ovf : 1'b0;
        end
      end else if (rsp_ready) begin
        state <= IDLE;
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (g1) begin
      lock_q <= lock1;
    end else begin
      lock_q <= lock_q && lock1 && req1_valid;
    end
  end
`endif

endmodule
